// File: rtl/poc_fifo_ctrl_if.sv
// Processor-bus and printer-handshake signal bundle for poc_fifo_ctrl.
// The master modport is the bus/printer side; the slave modport is the controller.
interface poc_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  logic              i_cs;
  logic              i_rw;
  logic [1:0]        i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] o_rdata;
  logic              o_irq_n;
  logic [DATA_W-1:0] o_pd;
  logic              o_tr;
  logic              i_rdy;

  modport master (
    output i_cs, i_rw, i_addr, i_wdata, i_rdy,
    input  o_rdata, o_irq_n, o_pd, o_tr
  );

  modport slave (
    input  i_cs, i_rw, i_addr, i_wdata, i_rdy,
    output o_rdata, o_irq_n, o_pd, o_tr
  );
endinterface

// File: rtl/poc_fifo_ctrl.sv
// Parallel output controller: register-mapped TX FIFO drained to a printer over a
// TR/RDY handshake with per-word timeout, polled status and level interrupt.
module poc_fifo_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic            i_clk,
  input logic            i_rst_n,
  poc_fifo_ctrl_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam int unsigned TcW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d, thresh_q, thresh_d;
  logic [TcW-1:0]        tcnt_q, tcnt_d;
  logic [DATA_W-1:0]     pd_q, pd_d, rdata_q, rdata_d;
  logic                  tr_q, tr_d, irq_n_q, irq_n_d;
  logic                  en_q, en_d, irq_mode_q, irq_mode_d;
  logic                  ovf_q, ovf_d, tmo_q, tmo_d;

  logic wr_en, rd_en, empty, full, push, flush, launch, tmo_set;

  always_comb begin
    wr_en  = bus.i_cs & bus.i_rw;
    rd_en  = bus.i_cs & ~bus.i_rw;
    empty  = (count_q == '0);
    full   = (count_q == CntW'(Depth));
    // Full is judged on pre-edge state, so a same-cycle pop never rescues a push.
    push   = wr_en && (bus.i_addr == 2'd0) && !full;
    flush  = wr_en && (bus.i_addr == 2'd2) && bus.i_wdata[2];
    launch = (state_q == StIdle) && en_q && !empty && bus.i_rdy;
  end

  // Printer handshake FSM
  always_comb begin
    state_d = state_q;
    tr_d    = tr_q;
    pd_d    = pd_q;
    tcnt_d  = tcnt_q;
    tmo_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (launch) begin
          pd_d    = mem_q[rptr_q];
          tr_d    = 1'b1;
          tcnt_d  = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (!bus.i_rdy) begin
          tr_d    = 1'b0;
          state_d = StWait;
        end else if ((TIMEOUT != 0) && (tcnt_q == TcW'(TIMEOUT - 1))) begin
          // Timed-out word is dropped, not re-queued.
          tr_d    = 1'b0;
          tmo_set = 1'b1;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StWait: begin
        tr_d = 1'b0;
        if (bus.i_rdy) state_d = StIdle;
      end
      default: begin
        tr_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // FIFO bookkeeping and register file
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    en_d       = en_q;
    irq_mode_d = irq_mode_q;
    thresh_d   = thresh_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    if (push)   wptr_d = wptr_q + 1'b1;
    if (launch) rptr_d = rptr_q + 1'b1;
    case ({push, launch})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    if (wr_en) begin
      case (bus.i_addr)
        2'd0: if (full) ovf_d = 1'b1;
        2'd1: begin
          if (bus.i_wdata[2]) ovf_d = 1'b0;
          if (bus.i_wdata[3]) tmo_d = 1'b0;
        end
        2'd2: begin
          en_d       = bus.i_wdata[0];
          irq_mode_d = bus.i_wdata[1];
        end
        default: thresh_d = CntW'(bus.i_wdata);
      endcase
    end
    if (tmo_set) tmo_d = 1'b1;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (bus.i_addr)
        2'd0:    rdata_d = DATA_W'(count_q);
        2'd1:    rdata_d = DATA_W'({(state_q != StIdle), tmo_q, ovf_q, full, empty});
        2'd2:    rdata_d = DATA_W'({irq_mode_q, en_q});
        default: rdata_d = DATA_W'(thresh_q);
      endcase
    end
    irq_n_d = ~(irq_mode_q & ((count_q <= thresh_q) | ovf_q | tmo_q));
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wptr_q] <= bus.i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      thresh_q   <= '0;
      tcnt_q     <= '0;
      pd_q       <= '0;
      rdata_q    <= '0;
      tr_q       <= 1'b0;
      irq_n_q    <= 1'b1;
      en_q       <= 1'b0;
      irq_mode_q <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      thresh_q   <= thresh_d;
      tcnt_q     <= tcnt_d;
      pd_q       <= pd_d;
      rdata_q    <= rdata_d;
      tr_q       <= tr_d;
      irq_n_q    <= irq_n_d;
      en_q       <= en_d;
      irq_mode_q <= irq_mode_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus.o_pd    = pd_q;
  assign bus.o_tr    = tr_q;
  assign bus.o_rdata = rdata_q;
  assign bus.o_irq_n = irq_n_q;

endmodule
